// File: rtl/sha_pkg.sv
// Shared definitions for the SHA-256/224 block controller: state codes,
// default geometry and the packed control word produced by the decoder.
package sha_pkg;

   localparam int ROUNDS_DEF = 64;
   localparam int BLK_W_DEF  = 16;
   localparam int ST_W       = 4;

   localparam logic [ST_W-1:0] S_IDLE   = 4'd0;
   localparam logic [ST_W-1:0] S_PAD    = 4'd1;
   localparam logic [ST_W-1:0] S_LOAD   = 4'd2;
   localparam logic [ST_W-1:0] S_LEN_LO = 4'd3;
   localparam logic [ST_W-1:0] S_LEN_HI = 4'd4;
   localparam logic [ST_W-1:0] S_INIT   = 4'd5;
   localparam logic [ST_W-1:0] S_WAIT   = 4'd6;
   localparam logic [ST_W-1:0] S_ROUND  = 4'd7;
   localparam logic [ST_W-1:0] S_UPDATE = 4'd8;
   localparam logic [ST_W-1:0] S_DONE   = 4'd9;

   typedef struct packed {
      logic padding_en;
      logic core_rst;
      logic core_en;
      logic load_hash_val;
      logic initial_hash_val;
      logic load_blocks_num;
      logic len_hi_lo_sel;
      logic data_len_sel;
      logic block_ready;
      logic busy;
      logic done;
   } ctrl_t;

endpackage

// File: rtl/sha_ctrl_decode.sv
// Moore output decode: maps the controller state onto the datapath control
// word. Anything not listed for a state stays low.
module sha_ctrl_decode
   import sha_pkg::*;
(
   input  logic [ST_W-1:0] state,
   output ctrl_t           ctrl
);

   always_comb begin
      ctrl      = '0;
      ctrl.busy = (state != S_IDLE);
      case (state)
         S_PAD:    ctrl.padding_en = 1'b1;
         S_LOAD: begin
            ctrl.core_rst        = 1'b1;
            ctrl.load_blocks_num = 1'b1;
         end
         S_LEN_LO: ctrl.data_len_sel = 1'b1;
         S_LEN_HI: begin
            ctrl.data_len_sel  = 1'b1;
            ctrl.len_hi_lo_sel = 1'b1;
         end
         S_INIT: begin
            ctrl.initial_hash_val = 1'b1;
            ctrl.load_hash_val    = 1'b1;
         end
         S_WAIT:   ctrl.block_ready   = 1'b1;
         S_ROUND:  ctrl.core_en       = 1'b1;
         S_UPDATE: ctrl.load_hash_val = 1'b1;
         S_DONE:   ctrl.done          = 1'b1;
         default:  ;
      endcase
   end

endmodule

// File: rtl/sha_ctrl_fsm.sv
// SHA-256/224 message controller: sequences padding, length injection,
// hash init, per-block compression rounds and digest hand-off.
module sha_ctrl_fsm
   import sha_pkg::*;
#(
   parameter  int ROUNDS = ROUNDS_DEF,
   parameter  int BLK_W  = BLK_W_DEF,
   localparam int RND_W  = $clog2(ROUNDS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             mode_224,
   input  logic             padding_done,
   input  logic [BLK_W-1:0] blocks_num,
   input  logic             block_valid,
   input  logic             ack,
   output logic             padding_en,
   output logic             core_rst,
   output logic             core_en,
   output logic             load_hash_val,
   output logic             initial_hash_val,
   output logic             load_blocks_num,
   output logic             len_hi_lo_sel,
   output logic             data_len_sel,
   output logic             init_mode_224,
   output logic             block_ready,
   output logic [RND_W-1:0] round_idx,
   output logic [BLK_W-1:0] blocks_left,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam logic [RND_W-1:0] RND_LAST = RND_W'(ROUNDS - 1);

   logic [ST_W-1:0]  state, nxt;
   logic [RND_W-1:0] round_cnt;
   logic [BLK_W-1:0] blocks_left_q;
   logic             err_q, mode_q;
   ctrl_t            ctrl;

   always_comb begin
      nxt = state;
      case (state)
         S_IDLE:   if (start) nxt = S_PAD;
         S_PAD:    if (padding_done) nxt = S_LOAD;
         S_LOAD:   nxt = (blocks_num == '0) ? S_DONE : S_LEN_LO;
         S_LEN_LO: nxt = S_LEN_HI;
         S_LEN_HI: nxt = S_INIT;
         S_INIT:   nxt = S_WAIT;
         S_WAIT:   if (block_valid) nxt = S_ROUND;
         S_ROUND:  if (round_cnt == RND_LAST) nxt = S_UPDATE;
         // <= 1 rather than == 1 so a corrupted zero count still terminates
         S_UPDATE: nxt = (blocks_left_q <= BLK_W'(1)) ? S_DONE : S_WAIT;
         S_DONE:   if (ack) nxt = S_IDLE;
         default:  nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         round_cnt     <= '0;
         blocks_left_q <= '0;
         err_q         <= 1'b0;
         mode_q        <= 1'b0;
      end else begin
         state <= nxt;
         case (state)
            S_IDLE: if (start) mode_q <= mode_224;
            S_LOAD: begin
               blocks_left_q <= blocks_num;
               err_q         <= (blocks_num == '0);
            end
            S_WAIT:  round_cnt <= '0;
            S_ROUND: round_cnt <= (round_cnt == RND_LAST) ? '0 : round_cnt + 1'b1;
            S_UPDATE: if (blocks_left_q != '0) blocks_left_q <= blocks_left_q - 1'b1;
            S_DONE:   if (ack) err_q <= 1'b0;
            default: ;
         endcase
      end
   end

   sha_ctrl_decode u_decode (
      .state (state),
      .ctrl  (ctrl)
   );

   assign padding_en       = ctrl.padding_en;
   assign core_rst         = ctrl.core_rst;
   assign core_en          = ctrl.core_en;
   assign load_hash_val    = ctrl.load_hash_val;
   assign initial_hash_val = ctrl.initial_hash_val;
   assign load_blocks_num  = ctrl.load_blocks_num;
   assign len_hi_lo_sel    = ctrl.len_hi_lo_sel;
   assign data_len_sel     = ctrl.data_len_sel;
   assign block_ready      = ctrl.block_ready;
   assign busy             = ctrl.busy;
   assign done             = ctrl.done;
   assign init_mode_224    = mode_q;
   assign err              = err_q;
   assign blocks_left      = blocks_left_q;
   assign round_idx        = ctrl.core_en ? round_cnt : '0;

endmodule
